pwr_domain_seq: RTL and testbench
=================================

# pwr_domain_seq

Power-domain sequencer that drives the control side of a switchable power domain's isolation cells. On request it runs the power-down sequence: isolate, save retention state, open the power switch. It then runs the matching power-up sequence: close the switch, hold domain reset, restore state, release isolation. It sits in the always-on domain, one instance per switchable domain, and its `iso_en` feeds every isolation cell on that domain's outputs.

## Interface
- `ISO_DLY`, 2: cycles `iso_en` is held before retention save (power-down), ≥1.
- `RET_CYC`, 1: width in cycles of `ret_save` / `ret_restore` pulses, ≥1.
- `RST_CYC`, 4: cycles domain reset is held after `pwr_good` rises, ≥1.
- `TIMEOUT`, 64: cycles waiting on `pwr_good` before flagging `err`, ≥1.

Ports:
- `clk`  in  1  single clock, always-on domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pwr_off_req`  in  1  level: 1 = domain should be off, 0 = on.
- `pwr_good`  in  1  power switch status from the domain (1 = rail up); already synchronised.
- `iso_en`  out  1  1 = isolate domain outputs.
- `ret_save`  out  1  retention save pulse.
- `ret_restore`  out  1  retention restore pulse.
- `pwr_sw_en`  out  1  1 = power switch closed (domain powered).
- `dom_rst_n`  out  1  domain reset, active-low.
- `pwr_off_ack`  out  1  level: 1 = domain fully off, 0 = fully on.
- `busy`  out  1  sequence in progress.
- `err`  out  1  sticky `pwr_good` timeout flag.

## Operation
- All outputs registered. Reset state ON: `iso_en`=0, `ret_save`=0, `ret_restore`=0, `pwr_sw_en`=1, `dom_rst_n`=1, `pwr_off_ack`=0, `busy`=0, `err`=0.
- Four-phase handshake. A sequence starts only when `pwr_off_req` != `pwr_off_ack` in ON or OFF.
- Requests that change mid-sequence are ignored until the sequence completes; no abort. A reverse request still pending at completion starts the opposite sequence on the next edge.

States and transitions:
- ON → ISO: `iso_en`=1.
- ISO → SAVE after `ISO_DLY` cycles: `ret_save`=1.
- SAVE → SW_OFF after `RET_CYC` cycles: `ret_save`=0, `pwr_sw_en`=0, `dom_rst_n`=0.
- SW_OFF → OFF on sampling `pwr_good`=0: `pwr_off_ack`=1.
- OFF → SW_ON: `pwr_sw_en`=1, `iso_en` and `dom_rst_n`=0 held.
- SW_ON → RST_HOLD on sampling `pwr_good`=1.
- RST_HOLD → RESTORE after `RST_CYC` cycles: `dom_rst_n`=1, `ret_restore`=1.
- RESTORE → ISO_REL after `RET_CYC` cycles: `ret_restore`=0.
- ISO_REL → ON next edge: `iso_en`=0, `pwr_off_ack`=0.

Other behaviour:
- `busy`=1 in every state except ON and OFF.
- `iso_en` is 1 whenever `pwr_sw_en`=0 or `dom_rst_n`=0. This is an invariant.
- Timeout: a wait counter runs in SW_OFF and SW_ON. Reaching `TIMEOUT` without the expected `pwr_good` level sets `err`=1. The FSM keeps waiting. `err` clears only on `rst_n`.
- Counter width is `$clog2` of the maximum of all parameters, +1. The counter reloads on every state entry.
- Asynchronous reset mid-sequence returns immediately to reset values, including `pwr_sw_en`=1.

## Timing
Power-down, E0 = edge sampling the request:
- `iso_en` rises at E0.
- `ret_save` is high E0+`ISO_DLY` to E0+`ISO_DLY`+`RET_CYC`.
- `pwr_sw_en` falls at E0+`ISO_DLY`+`RET_CYC`.
- `pwr_off_ack` rises on the edge sampling `pwr_good`=0.

Power-up, E0 = edge sampling the request:
- `pwr_sw_en` rises at E0.
- Ek = edge sampling `pwr_good`=1.
- `dom_rst_n` and `ret_restore` rise at Ek+`RST_CYC`.
- `ret_restore` falls at Ek+`RST_CYC`+`RET_CYC`.
- `iso_en` and `pwr_off_ack` fall one edge later.

## Configuration
- `PWR_SEQ_RETENTION_EN` defined: SAVE and RESTORE states present, as above.
- Not defined: SAVE and RESTORE are skipped.
  - ISO → SW_OFF after `ISO_DLY`.
  - RST_HOLD → ISO_REL after `RST_CYC`, with `dom_rst_n` rising on that edge.
  - `ret_save` and `ret_restore` are tied 0. Ports remain.

## Test plan
- Defaults, retention on: `pwr_off_req`=1 at E0, `pwr_good` falls after E3.
  - `iso_en`=1@E0, `ret_save`=1@E2..E3, `pwr_sw_en`=0@E3, `pwr_off_ack`=1 on first edge sampling `pwr_good`=0.
- Power-up from OFF: `pwr_off_req`=0 at E0, `pwr_good`=1 sampled at E2.
  - `dom_rst_n`=1 and `ret_restore`=1 @E6, `ret_restore`=0 @E7, `iso_en`=0 and `pwr_off_ack`=0 @E8.
- `pwr_good` stuck high after switch-off: `err`=1 exactly `TIMEOUT`=64 cycles after SW_OFF entry, still SW_OFF.
  - Later `pwr_good`=0 reaches OFF with `err` still 1.
- Request toggled 1→0 during ISO: power-down completes to OFF with `pwr_off_ack`=1, then power-up starts on the next edge.
- `rst_n` pulsed low in SW_OFF: outputs return to reset values asynchronously, `pwr_sw_en`=1, `iso_en`=0, `err`=0.
- Macro undefined, full down/up cycle: `ret_save` and `ret_restore` are never 1.
  - `pwr_sw_en` falls at E2; `dom_rst_n` rises at Ek+4.
  - Invariant `iso_en` holds throughout.

Source files
------------

// File: rtl/pwr_domain_seq.sv
// pwr_domain_seq: isolation/retention/switch/reset sequencer for one switchable power domain.
// Define PWR_SEQ_RETENTION_EN to include the SAVE and RESTORE retention phases.
module pwr_domain_seq #(
    parameter int ISO_DLY = 2,
    parameter int RET_CYC = 1,
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwr_off_req,
    input  logic pwr_good,
    output logic iso_en,
    output logic ret_save,
    output logic ret_restore,
    output logic pwr_sw_en,
    output logic dom_rst_n,
    output logic pwr_off_ack,
    output logic busy,
    output logic err
);
    localparam int M0 = ISO_DLY > RET_CYC ? ISO_DLY : RET_CYC;
    localparam int M1 = RST_CYC > TIMEOUT ? RST_CYC : TIMEOUT;
    localparam int CW = $clog2(M0 > M1 ? M0 : M1) + 1;
    localparam logic [CW-1:0] ISO_LD = CW'(ISO_DLY - 1);
    localparam logic [CW-1:0] RST_LD = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT - 1);
`ifdef PWR_SEQ_RETENTION_EN
    localparam logic [CW-1:0] RET_LD = CW'(RET_CYC - 1);
`endif

    typedef enum logic [3:0] {
        ON, ISO, SAVE, SW_OFF, OFF, SW_ON, RST_HOLD, RESTORE, ISO_REL
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ON;
            cnt         <= '0;
            iso_en      <= 1'b0;
            ret_save    <= 1'b0;
            ret_restore <= 1'b0;
            pwr_sw_en   <= 1'b1;
            dom_rst_n   <= 1'b1;
            pwr_off_ack <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                ON: if (pwr_off_req) begin
                    state  <= ISO;
                    cnt    <= ISO_LD;
                    iso_en <= 1'b1;
                    busy   <= 1'b1;
                end
                ISO: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
`ifdef PWR_SEQ_RETENTION_EN
                    state    <= SAVE;
                    cnt      <= RET_LD;
                    ret_save <= 1'b1;
`else
                    state     <= SW_OFF;
                    cnt       <= TO_LD;
                    pwr_sw_en <= 1'b0;
                    dom_rst_n <= 1'b0;
`endif
                end
`ifdef PWR_SEQ_RETENTION_EN
                SAVE: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state     <= SW_OFF;
                    cnt       <= TO_LD;
                    ret_save  <= 1'b0;
                    pwr_sw_en <= 1'b0;
                    dom_rst_n <= 1'b0;
                end
`endif
                // Waits never give up; the timeout only raises the sticky flag.
                SW_OFF: if (!pwr_good) begin
                    state       <= OFF;
                    pwr_off_ack <= 1'b1;
                    busy        <= 1'b0;
                end else if (cnt != '0) cnt <= cnt - 1'b1;
                else err <= 1'b1;
                OFF: if (!pwr_off_req) begin
                    state     <= SW_ON;
                    cnt       <= TO_LD;
                    pwr_sw_en <= 1'b1;
                    busy      <= 1'b1;
                end
                SW_ON: if (pwr_good) begin
                    state <= RST_HOLD;
                    cnt   <= RST_LD;
                end else if (cnt != '0) cnt <= cnt - 1'b1;
                else err <= 1'b1;
                RST_HOLD: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    dom_rst_n <= 1'b1;
`ifdef PWR_SEQ_RETENTION_EN
                    state       <= RESTORE;
                    cnt         <= RET_LD;
                    ret_restore <= 1'b1;
`else
                    state <= ISO_REL;
`endif
                end
`ifdef PWR_SEQ_RETENTION_EN
                RESTORE: if (cnt != '0) cnt <= cnt - 1'b1;
                else begin
                    state       <= ISO_REL;
                    ret_restore <= 1'b0;
                end
`endif
                ISO_REL: begin
                    state       <= ON;
                    iso_en      <= 1'b0;
                    pwr_off_ack <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= ON;
            endcase
        end
    end
endmodule

// File: tb/tb_pwr_domain_seq.sv
// tb_pwr_domain_seq: directed and randomized checks of pwr_domain_seq against a timeline model.
module tb_pwr_domain_seq;
    localparam int ISO_DLY = 2;
    localparam int RET_CYC = 1;
    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 64;
`ifdef PWR_SEQ_RETENTION_EN
    localparam bit R = 1'b1;
`else
    localparam bit R = 1'b0;
`endif
    localparam int SW_E   = ISO_DLY + (R ? RET_CYC : 0);
    localparam int DONE_E = 2 + RST_CYC + (R ? RET_CYC : 0) + 1;

    logic clk = 1'b0, rst_n = 1'b0, pwr_off_req = 1'b0, pwr_good = 1'b1;
    logic iso_en, ret_save, ret_restore, pwr_sw_en, dom_rst_n, pwr_off_ack, busy, err;
    int vec = 0, miss = 0;

    pwr_domain_seq #(.ISO_DLY(ISO_DLY), .RET_CYC(RET_CYC), .RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .pwr_off_req(pwr_off_req), .pwr_good(pwr_good),
        .iso_en(iso_en), .ret_save(ret_save), .ret_restore(ret_restore), .pwr_sw_en(pwr_sw_en),
        .dom_rst_n(dom_rst_n), .pwr_off_ack(pwr_off_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Model: 0 = on, 1 = powering down, 2 = off, 3 = powering up; t counts edges since the start edge.
    int m_mode = 0, m_t = 0, m_k = -1;
    bit m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_t = 0; m_k = -1; m_err = 1'b0;
        end else begin
            case (m_mode)
                0: if (pwr_off_req) begin m_mode = 1; m_t = 0; m_k = -1; end
                2: if (!pwr_off_req) begin m_mode = 3; m_t = 0; m_k = -1; end
                1: begin
                    m_t++;
                    if (m_t > SW_E && !pwr_good) m_mode = 2;
                    else if (m_t >= SW_E + TIMEOUT) m_err = 1'b1;
                end
                default: begin
                    m_t++;
                    if (m_k < 0) begin
                        if (pwr_good) m_k = m_t;
                        else if (m_t >= TIMEOUT) m_err = 1'b1;
                    end else if (m_t == m_k + RST_CYC + (R ? RET_CYC : 0) + 1) m_mode = 0;
                end
            endcase
        end
    end

    function automatic logic [7:0] exp_vec();
        logic s, rs, sw, dr;
        case (m_mode)
            0: return {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, m_err};
            2: return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_err};
            1: begin
                s  = R && m_t >= ISO_DLY && m_t < ISO_DLY + RET_CYC;
                sw = m_t < SW_E;
                return {1'b1, s, 1'b0, sw, sw, 1'b0, 1'b1, m_err};
            end
            default: begin
                dr = m_k >= 0 && m_t >= m_k + RST_CYC;
                rs = R && dr && m_t < m_k + RST_CYC + RET_CYC;
                return {1'b1, 1'b0, rs, 1'b1, dr, 1'b1, 1'b1, m_err};
            end
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        chk("model", {iso_en, ret_save, ret_restore, pwr_sw_en, dom_rst_n, pwr_off_ack, busy, err}, exp_vec());
        chk("iso_invariant", {7'd0, iso_en | (pwr_sw_en & dom_rst_n)}, 8'd1);
    end

    task automatic nxt();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int stuck = 0;
    initial begin
        @(negedge clk);
        chk("reset_vals", {iso_en, ret_save, ret_restore, pwr_sw_en, dom_rst_n, pwr_off_ack, busy, err}, 8'b0001_1000);
        rst_n = 1'b1;
        nxt();
        // Directed power-down
        pwr_off_req = 1'b1;
        nxt();
        chk("dn_iso_e0", {7'd0, iso_en}, 8'd1);
        for (int e = 1; e <= SW_E; e++) begin
            nxt();
            if (e == ISO_DLY) chk("dn_save", {7'd0, ret_save}, {7'd0, R});
            if (e == SW_E - 1) chk("dn_sw_before", {7'd0, pwr_sw_en}, 8'd1);
            if (e == SW_E) chk("dn_sw_off", {6'd0, pwr_sw_en, dom_rst_n}, 8'd0);
        end
        nxt();
        chk("dn_no_ack_pg1", {7'd0, pwr_off_ack}, 8'd0);
        pwr_good = 1'b0;
        nxt();
        chk("dn_ack", {7'd0, pwr_off_ack}, 8'd1);
        // Directed power-up, pwr_good sampled high at E2
        pwr_off_req = 1'b0;
        nxt();
        chk("up_sw_e0", {7'd0, pwr_sw_en}, 8'd1);
        nxt();
        pwr_good = 1'b1;
        nxt();
        for (int e = 3; e <= DONE_E; e++) begin
            nxt();
            if (e == 2 + RST_CYC - 1) chk("up_rst_held", {7'd0, dom_rst_n}, 8'd0);
            if (e == 2 + RST_CYC) chk("up_rst_rel", {6'd0, dom_rst_n, ret_restore}, {6'd0, 1'b1, R});
            if (e == DONE_E - 1) chk("up_iso_held", {7'd0, iso_en}, 8'd1);
            if (e == DONE_E) chk("up_done", {5'd0, iso_en, pwr_off_ack, busy}, 8'd0);
        end
        // pwr_good stuck high after switch-off
        pwr_off_req = 1'b1;
        nxt();
        for (int e = 1; e <= SW_E + TIMEOUT; e++) begin
            nxt();
            if (e == SW_E + TIMEOUT - 1) chk("to_err_before", {7'd0, err}, 8'd0);
            if (e == SW_E + TIMEOUT) chk("to_err_set", {5'd0, err, pwr_sw_en, pwr_off_ack}, 8'b100);
        end
        pwr_good = 1'b0;
        nxt();
        chk("to_off_err", {6'd0, pwr_off_ack, err}, 8'b11);
        pwr_off_req = 1'b0;
        nxt();
        pwr_good = 1'b1;
        repeat (12) nxt();
        chk("to_back_on", {5'd0, pwr_off_ack, busy, err}, 8'b001);
        // Request withdrawn during ISO
        pwr_off_req = 1'b1;
        nxt();
        pwr_off_req = 1'b0;
        for (int i = 0; i < 20 && !pwr_off_ack; i++) begin
            nxt();
            if (!pwr_sw_en) pwr_good = 1'b0;
        end
        chk("tog_off", {7'd0, pwr_off_ack}, 8'd1);
        nxt();
        chk("tog_up_start", {6'd0, pwr_sw_en, busy}, 8'b11);
        pwr_good = 1'b1;
        repeat (12) nxt();
        // Async reset while in SW_OFF
        pwr_off_req = 1'b1;
        nxt();
        repeat (SW_E + 1) nxt();
        #2 rst_n = 1'b0;
        #1 chk("arst_vals", {iso_en, ret_save, ret_restore, pwr_sw_en, dom_rst_n, pwr_off_ack, busy, err}, 8'b0001_1000);
        pwr_off_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Randomized traffic with a loosely-following rail and occasional stuck periods
        for (int c = 0; c < 3000; c++) begin
            nxt();
            if ($urandom_range(0, 39) == 0) pwr_off_req = !pwr_off_req;
            if (stuck > 0) stuck--;
            else if ($urandom_range(0, 299) == 0) stuck = $urandom_range(40, 90);
            else if ($urandom_range(0, 2) == 0) pwr_good = pwr_sw_en;
            else if ($urandom_range(0, 49) == 0) pwr_good = !pwr_good;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
